// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a double-buffered, frame-synchronous window overlay.
// Optional build macro WIN_CLAMP_EN: clamp captured window edges so the window fits the visible area.
module vga_timing_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 400,
    parameter int   V_FRONT   = 12,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 35,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b1,
    parameter int   WIN_W     = 8,
    parameter int   WIN_H     = 16,
    parameter int   WIN_X0    = 475,
    parameter int   WIN_Y0    = 241
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic [9:0] win_x_in,
    input  logic [9:0] win_y_in,
    input  logic       win_load,
    output logic       win_pending,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       win_active,
    output logic [3:0] win_col,
    output logic [3:0] win_row,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Counters widen beyond 10 bits for modes with more than 1024 clocks per line;
    // the x/y ports then carry the low 10 bits.
    localparam int HW  = (H_TOTAL > 1024) ? $clog2(H_TOTAL) : 10;
    localparam int VW  = (V_TOTAL > 1024) ? $clog2(V_TOTAL) : 10;
    localparam int HXW = HW + 1;
    localparam int VXW = VW + 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;
    logic [9:0]    wx_q, wy_q;
    logic [9:0]    sx_q, sy_q;
    logic          pend_q;
    logic [9:0]    cap_x, cap_y;
    logic          line_end, frame_end;

`ifdef WIN_CLAMP_EN
    localparam logic [9:0] X_MAX = 10'(H_VISIBLE - WIN_W);
    localparam logic [9:0] Y_MAX = 10'(V_VISIBLE - WIN_H);
    assign cap_x = (win_x_in > X_MAX) ? X_MAX : win_x_in;
    assign cap_y = (win_y_in > Y_MAX) ? Y_MAX : win_y_in;
`else
    assign cap_x = win_x_in;
    assign cap_y = win_y_in;
`endif

    assign line_end  = (x_q == H_LAST);
    assign frame_end = line_end && (y_q == V_LAST);

    always_comb begin
        x_d = line_end ? '0 : x_q + 1'b1;
        y_d = y_q;
        if (line_end) begin
            y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
        end
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            wx_q   <= 10'(WIN_X0);
            wy_q   <= 10'(WIN_Y0);
            sx_q   <= 10'(WIN_X0);
            sy_q   <= 10'(WIN_Y0);
            pend_q <= 1'b0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            // The shadow value that was pending before this edge is the one applied,
            // even when a new load lands on the same edge.
            if (frame_end && pend_q) begin
                wx_q <= sx_q;
                wy_q <= sy_q;
            end
            if (win_load) begin
                sx_q   <= cap_x;
                sy_q   <= cap_y;
                pend_q <= 1'b1;
            end else if (frame_end) begin
                pend_q <= 1'b0;
            end
        end
    end

    logic [HXW-1:0] wx_end;
    logic [VXW-1:0] wy_end;
    logic           in_x, in_y;

    assign wx_end = HXW'(wx_q) + HXW'(WIN_W);
    assign wy_end = VXW'(wy_q) + VXW'(WIN_H);
    assign in_x   = (HXW'(x_q) >= HXW'(wx_q)) && (HXW'(x_q) < wx_end);
    assign in_y   = (VXW'(y_q) >= VXW'(wy_q)) && (VXW'(y_q) < wy_end);

    assign video_on    = (x_q < H_VIS) && (y_q < V_VIS);
    assign win_active  = in_x && in_y && video_on;
    assign win_col     = win_active ? 4'(HXW'(x_q) - HXW'(wx_q)) : 4'd0;
    assign win_row     = win_active ? 4'(VXW'(y_q) - VXW'(wy_q)) : 4'd0;
    assign hsync       = ((x_q >= HS_BEG) && (x_q < HS_END)) ? HS_POL : ~HS_POL;
    assign vsync       = ((y_q >= VS_BEG) && (y_q < VS_END)) ? VS_POL : ~VS_POL;
    assign line_start  = (x_q == '0);
    assign frame_start = line_start && (y_q == '0);
    assign win_pending = pend_q;
    assign x           = 10'(x_q);
    assign y           = 10'(y_q);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: stimulus queues hand-computed expectations tagged with the negedge they
// apply to; the monitor compares every queued entry when that negedge arrives.
module tb_vga_timing_gen;

    logic       clk25 = 1'b0;
    logic       reset;
    logic [9:0] win_x_in, win_y_in;
    logic       win_load;

    always #20 clk25 = ~clk25;

    // Small raster: H 64/4/8/4 = 80, V 40/2/2/3 = 47, window 8x16 at (10,5).
    logic       pend, hs, vs, vid, wa, ls, fs;
    logic [9:0] xo, yo;
    logic [3:0] wc, wr;
    vga_timing_gen #(
        .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(40), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .HS_POL(1'b0), .VS_POL(1'b1), .WIN_W(8), .WIN_H(16), .WIN_X0(10), .WIN_Y0(5)
    ) u_dut (
        .clk25(clk25), .reset(reset), .win_x_in(win_x_in), .win_y_in(win_y_in),
        .win_load(win_load), .win_pending(pend), .hsync(hs), .vsync(vs), .video_on(vid),
        .x(xo), .y(yo), .win_active(wa), .win_col(wc), .win_row(wr),
        .line_start(ls), .frame_start(fs)
    );

    // Default 640x400 timing.
    logic       d_pend, d_hs, d_vs, d_vid, d_wa, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic [3:0] d_wc, d_wr;
    vga_timing_gen u_def (
        .clk25(clk25), .reset(reset), .win_x_in(win_x_in), .win_y_in(win_y_in),
        .win_load(win_load), .win_pending(d_pend), .hsync(d_hs), .vsync(d_vs), .video_on(d_vid),
        .x(d_x), .y(d_y), .win_active(d_wa), .win_col(d_wc), .win_row(d_wr),
        .line_start(d_ls), .frame_start(d_fs)
    );

    // 800x600 timing with positive hsync.
    logic       s_pend, s_hs, s_vs, s_vid, s_wa, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic [3:0] s_wc, s_wr;
    vga_timing_gen #(
        .H_VISIBLE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
        .V_VISIBLE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23), .HS_POL(1'b1)
    ) u_svga (
        .clk25(clk25), .reset(reset), .win_x_in(win_x_in), .win_y_in(win_y_in),
        .win_load(win_load), .win_pending(s_pend), .hsync(s_hs), .vsync(s_vs), .video_on(s_vid),
        .x(s_x), .y(s_y), .win_active(s_wa), .win_col(s_wc), .win_row(s_wr),
        .line_start(s_ls), .frame_start(s_fs)
    );

    localparam int S_X = 0, S_Y = 1, S_HS = 2, S_VS = 3, S_VID = 4, S_WA = 5, S_WC = 6,
                   S_WR = 7, S_LS = 8, S_FS = 9, S_PEND = 10, D_X = 11, D_HS = 12,
                   V_HS = 13, V_LS = 14;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    exp_t sb[$];
    int   ncyc   = 0;
    int   errors = 0;
    int   checks = 0;

    function automatic int actual(int sig);
        case (sig)
            S_X:     return int'(xo);
            S_Y:     return int'(yo);
            S_HS:    return int'(hs);
            S_VS:    return int'(vs);
            S_VID:   return int'(vid);
            S_WA:    return int'(wa);
            S_WC:    return int'(wc);
            S_WR:    return int'(wr);
            S_LS:    return int'(ls);
            S_FS:    return int'(fs);
            S_PEND:  return int'(pend);
            D_X:     return int'(d_x);
            D_HS:    return int'(d_hs);
            V_HS:    return int'(s_hs);
            V_LS:    return int'(s_ls);
            default: return -1;
        endcase
    endfunction

    function automatic string sname(int sig);
        case (sig)
            S_X:     return "x";
            S_Y:     return "y";
            S_HS:    return "hsync";
            S_VS:    return "vsync";
            S_VID:   return "video_on";
            S_WA:    return "win_active";
            S_WC:    return "win_col";
            S_WR:    return "win_row";
            S_LS:    return "line_start";
            S_FS:    return "frame_start";
            S_PEND:  return "win_pending";
            D_X:     return "def_x";
            D_HS:    return "def_hsync";
            V_HS:    return "svga_hsync";
            V_LS:    return "svga_line_start";
            default: return "unknown";
        endcase
    endfunction

    always @(negedge clk25) begin
        int i;
        ncyc = ncyc + 1;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == ncyc) begin
                checks = checks + 1;
                if (actual(sb[i].sig) != sb[i].val) begin
                    errors = errors + 1;
                    $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                             sname(sb[i].sig), ncyc, actual(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end else begin
                i = i + 1;
            end
        end
    end

    // Expect sig==val in the state reached after e more rising edges.
    task automatic exp_after(input int e, input int sig, input int val);
        exp_t t;
        t.cyc = ncyc + e + 1;
        t.sig = sig;
        t.val = val;
        sb.push_back(t);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk25);
        #2;
    endtask

    task automatic load(input int lx, input int ly);
        win_x_in = 10'(lx);
        win_y_in = 10'(ly);
        win_load = 1'b1;
        tick(1);
        win_load = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        win_x_in = '0;
        win_y_in = '0;
        win_load = 1'b0;
        tick(1);
        checks = checks + 1;
        if (xo !== 10'd0) begin
            errors = errors + 1;
            $display("FAIL x in reset: got %0d, expected 0", xo);
        end
        checks = checks + 1;
        if (fs !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL frame_start in reset: got %0b, expected 1", fs);
        end
        checks = checks + 1;
        if (d_hs !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL def_hsync in reset: got %0b, expected 1", d_hs);
        end
        exp_after(0, S_X, 0);   exp_after(0, S_Y, 0);    exp_after(0, S_HS, 1);
        exp_after(0, S_VS, 0);  exp_after(0, S_LS, 1);   exp_after(0, S_FS, 1);
        exp_after(0, S_PEND, 0); exp_after(0, D_HS, 1);  exp_after(0, V_HS, 0);
        exp_after(0, D_X, 0);
        tick(2);
        reset = 1'b0;

        // Elapsed counter E = rising edges since release; small raster x = E%80, y = E/80.
        exp_after(0, S_X, 0);      exp_after(1, S_X, 1);
        exp_after(67, S_HS, 1);    exp_after(68, S_HS, 0);
        exp_after(75, S_HS, 0);    exp_after(76, S_HS, 1);
        exp_after(63, S_VID, 1);   exp_after(64, S_VID, 0);
        exp_after(79, S_X, 79);    exp_after(80, S_X, 0);
        exp_after(80, S_Y, 1);     exp_after(80, S_LS, 1);   exp_after(81, S_LS, 0);
        exp_after(655, D_HS, 1);   exp_after(656, D_HS, 0);
        exp_after(751, D_HS, 0);   exp_after(752, D_HS, 1);
        exp_after(799, D_X, 799);  exp_after(800, D_X, 0);
        exp_after(839, V_HS, 0);   exp_after(840, V_HS, 1);
        exp_after(967, V_HS, 1);   exp_after(968, V_HS, 0);
        exp_after(1055, V_LS, 0);  exp_after(1056, V_LS, 1);
        exp_after(3359, S_VS, 0);  exp_after(3360, S_VS, 1);
        exp_after(3519, S_VS, 1);  exp_after(3520, S_VS, 0);
        exp_after(3759, S_FS, 0);  exp_after(3760, S_FS, 1);  exp_after(3761, S_FS, 0);
        exp_after(409, S_WA, 0);   exp_after(410, S_WA, 1);
        exp_after(410, S_WC, 0);   exp_after(410, S_WR, 0);
        exp_after(1617, S_WA, 1);  exp_after(1617, S_WC, 7);  exp_after(1617, S_WR, 15);
        exp_after(1618, S_WA, 0);  exp_after(1618, S_WC, 0);
        exp_after(1690, S_WA, 0);  exp_after(1690, S_WR, 0);

        // Load (20,12) at E=805 (y=10); applies on the frame wrap at E=3760.
        tick(805);
        exp_after(0, S_PEND, 0);
        exp_after(1, S_PEND, 1);
        load(20, 12);
        exp_after(2953, S_PEND, 1);  exp_after(2954, S_PEND, 0);
        exp_after(3364, S_WA, 0);
        exp_after(3933, S_WA, 0);    exp_after(3934, S_WA, 1);
        exp_after(5134, S_WA, 1);    exp_after(5134, S_WC, 0);  exp_after(5134, S_WR, 15);

        // Load (30,20) at E=6000, then (40,25) on the apply edge E=7520.
        tick(5194);
        load(30, 20);
        exp_after(0, S_PEND, 1);
        tick(1518);
        win_x_in = 10'd40;
        win_y_in = 10'd25;
        win_load = 1'b1;
        exp_after(1, S_PEND, 1);
        tick(1);
        win_load = 1'b0;
        exp_after(1629, S_WA, 0);   exp_after(1630, S_WA, 1);
        exp_after(1630, S_WC, 0);   exp_after(1630, S_WR, 0);
        exp_after(3759, S_PEND, 1); exp_after(3760, S_PEND, 0);
        exp_after(5799, S_WA, 0);   exp_after(5800, S_WA, 1);

        // Window near the bottom-right corner, loaded at E=13400, applied at E=15040.
        tick(5880);
        load(60, 38);
`ifdef WIN_CLAMP_EN
        exp_after(4742, S_WA, 1);  exp_after(4742, S_WC, 7);  exp_after(4742, S_WR, 14);
        exp_after(4739, S_WA, 1);  exp_after(4739, S_WC, 4);
        exp_after(3615, S_WA, 1);  exp_after(3615, S_WC, 0);
`else
        exp_after(4742, S_WA, 1);  exp_after(4742, S_WC, 3);  exp_after(4742, S_WR, 0);
        exp_after(4739, S_WA, 1);  exp_after(4739, S_WC, 0);
        exp_after(3615, S_WA, 0);
`endif
        exp_after(4743, S_WA, 0);  exp_after(4743, S_WC, 0);
        exp_after(4899, S_WA, 0);  exp_after(4899, S_WR, 0);

        // Reset mid-line at default-raster x=300 with a load just captured.
        tick(5298);
        exp_after(0, D_X, 299);
        load(5, 5);
        reset = 1'b1;
        exp_after(0, S_X, 0);     exp_after(0, D_X, 0);    exp_after(0, S_Y, 0);
        exp_after(0, S_PEND, 0);  exp_after(0, S_FS, 1);   exp_after(0, S_HS, 1);
        tick(3);
        reset = 1'b0;
        exp_after(0, S_X, 0);     exp_after(1, S_X, 1);    exp_after(1, D_X, 1);
        exp_after(410, S_WA, 1);  exp_after(3760, S_PEND, 0);
        exp_after(4165, S_WA, 0); exp_after(4170, S_WA, 1); exp_after(4170, S_WC, 0);
        tick(4200);

        checks = checks + 1;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard not drained: %0d entries left", sb.size());
        end
        foreach (sb[i]) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s never reached (cycle %0d): got none, expected %0d",
                     sname(sb[i].sig), sb[i].cyc, sb[i].val);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL expose the following parameters, one per line: name, default, meaning.
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 400, visible lines per frame
- V_FRONT, 12, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 35, vertical back porch in lines
- HS_POL, 0, hsync level while asserted (0 = active-low)
- VS_POL, 1, vsync level while asserted
- WIN_W, 8, window width in pixels (power of 2, 1..16)
- WIN_H, 16, window height in lines (power of 2, 1..16)
- WIN_X0, 475, window left edge after reset
- WIN_Y0, 241, window top edge after reset

REQ-002 The block SHALL expose the following ports, one per line: name, direction, width, meaning.
- clk25, in, 1, pixel clock; reset is asynchronous and active-high
- reset, in, 1, asynchronous active-high reset
- win_x_in, in, 10, requested window left edge
- win_y_in, in, 10, requested window top edge
- win_load, in, 1, one-cycle request to capture win_x_in/win_y_in
- win_pending, out, 1, captured position not yet applied
- hsync, out, 1, horizontal sync at HS_POL
- vsync, out, 1, vertical sync at VS_POL
- video_on, out, 1, pixel in visible area
- x, out, 10, pixel counter
- y, out, 10, line counter
- win_active, out, 1, pixel inside window
- win_col, out, 4, x minus window left edge (0 outside window)
- win_row, out, 4, y minus window top edge (0 outside window)
- line_start, out, 1, high when x==0
- frame_start, out, 1, high when x==0 and y==0

Function
REQ-003 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL SHALL equal the sum of the four vertical parameters (defaults 800/449).
REQ-004 x SHALL increment every clk25 and wrap from H_TOTAL-1 to 0; y SHALL increment when x wraps and wrap from V_TOTAL-1 to 0.
REQ-005 Line order SHALL be visible [0,H_VISIBLE), front porch, sync, back porch; the vertical order SHALL be the same.
REQ-006 hsync SHALL equal HS_POL for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC, and the inverse otherwise; vsync SHALL follow the same rule with the vertical parameters and VS_POL.
REQ-007 video_on SHALL be 1 iff x<H_VISIBLE and y<V_VISIBLE.
REQ-008 All outputs SHALL be combinational decodes of registered state, with zero cycles of latency relative to x/y.
REQ-009 The active window edges (wx, wy) SHALL be registers; win_active SHALL be 1 iff wx<=x<wx+WIN_W and wy<=y<wy+WIN_H, with the sums computed 11 bits wide so they do not wrap.
REQ-010 When win_load is high, win_x_in/win_y_in SHALL be captured into shadow registers and win_pending SHALL be set on the next edge; a later win_load before the position is applied SHALL overwrite the shadow registers.
REQ-011 On the edge where x==H_TOTAL-1 and y==V_TOTAL-1, pending shadow values SHALL be copied into wx/wy and win_pending SHALL clear; the window SHALL never change mid-frame.
REQ-012 If win_load coincides with the apply edge, the new values SHALL be captured, win_pending SHALL remain 1, and the old shadow values SHALL be applied.
REQ-013 A window extending past the visible area SHALL clip naturally, with win_active gated by video_on.

Reset
REQ-014 While reset is high, the following SHALL hold:
- x=0, y=0
- wx=WIN_X0, wy=WIN_Y0, shadow registers equal to wx/wy
- win_pending=0
- hsync=~HS_POL, vsync=~VS_POL
- line_start=1, frame_start=1
- a pending load in progress is discarded
REQ-015 Counting SHALL resume on the first clk25 edge after reset deasserts.

Configuration
REQ-016 With WIN_CLAMP_EN defined, captured win_x_in SHALL be clamped to H_VISIBLE-WIN_W and win_y_in to V_VISIBLE-WIN_H; without WIN_CLAMP_EN, values SHALL be stored unmodified.

Verification
REQ-017 Free-run with default parameters:
- frame_start period = 359200 clocks
- hsync low for x in 656..751
- vsync high for y in 412..413
REQ-018 Reset asserted mid-line at x=300 -> outputs at reset values within the same cycle; x=1 on the first edge after release.
REQ-019 win_load with (100,50) at y=10 -> win_pending=1 until the frame wrap; first win_active at x=100, y=50 of the next frame; win_row=15 at y=65.
REQ-020 win_load asserted on the apply edge -> old shadow applied, new values pending, applied one frame later.
REQ-021 win_load with (636,398), WIN_CLAMP_EN defined -> wx=632, wy=384; undefined -> win_active only at x 636..639, y 398..399.
REQ-022 Parameters overridden to 800x600 (40/128/88, 1/4/23), HS_POL=1 -> H_TOTAL=1056, V_TOTAL=628, hsync high for x 840..967.
